ps2_rx: RTL and testbench



---
 rtl/ps2_rx_if.sv | 21 ++
 rtl/ps2_rx.sv | 144 ++++++++++++++
 tb/tb_ps2_rx.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ps2_rx_if.sv
// ps2_rx_if: PS/2 line pair in, received byte and status strobes out.
// The receiver connects through the slave modport; whatever drives the PS/2
// lines and consumes the bytes uses the master modport.
interface ps2_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] data;
  logic       write;
  logic       err;
  logic       busy;

  modport slave (
    input  ps2_clk, ps2_data,
    output data, write, err, busy
  );

  modport master (
    output ps2_clk, ps2_data,
    input  data, write, err, busy
  );
endinterface

// File: rtl/ps2_rx.sv
// ps2_rx: PS/2 device-to-host frame receiver.
// Synchronises ps2_clk/ps2_data, deframes start + 8 data (LSB first) +
// odd parity + stop, and emits each good byte as a one-cycle write strobe
// (feeds an 8-bit FIFO). Bad frames and stalled frames give a one-cycle err.
// Optional feature macro: PS2_PARITY_CHECK_EN -- when defined, a parity
// mismatch is treated as a frame error; when undefined, parity is ignored.
module ps2_rx #(
  parameter int unsigned TIMEOUT = 10000
) (
  input  logic     clk,
  input  logic     clrn,
  ps2_rx_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  // [0],[1] form the synchroniser; [2] is the previous synced value for edge detect
  logic [2:0]  clk_sync_q, clk_sync_d;
  logic [1:0]  dat_sync_q, dat_sync_d;
  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [15:0] tmo_q, tmo_d;
  logic [7:0]  sr_q, sr_d;
  logic [7:0]  data_q, data_d;
  logic        write_q, write_d;
  logic        err_q, err_d;
  logic        busy_q, busy_d;
`ifdef PS2_PARITY_CHECK_EN
  logic        par_q, par_d;
`endif

  logic fall;
  logic din;
  logic frame_ok;

  assign fall = clk_sync_q[2] & ~clk_sync_q[1];
  assign din  = dat_sync_q[1];

  // Stop bit must be 1; parity only counts when the check is compiled in
  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    frame_ok = din & (^{sr_q, par_q});
`else
    frame_ok = din;
`endif
  end

  // Next-state logic: synchroniser shift, frame FSM, timeout and output strobes
  always_comb begin
    clk_sync_d = {clk_sync_q[1:0], bus.ps2_clk};
    dat_sync_d = {dat_sync_q[0], bus.ps2_data};
    state_d    = state_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    sr_d       = sr_q;
    data_d     = data_q;
    write_d    = 1'b0;
    err_d      = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    par_d      = par_q;
`endif
    if (state_q == IDLE) begin
      // A falling edge with data high is a glitch, not a start bit
      if (fall && !din) begin
        state_d = DATA;
        cnt_d   = 3'd0;
        tmo_d   = 16'd0;
      end
    end else if (fall) begin
      tmo_d = 16'd0;
      case (state_q)
        DATA: begin
          sr_d  = {din, sr_q[7:1]};
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          par_d = din;
`endif
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (frame_ok) begin
            data_d  = sr_q;
            write_d = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (tmo_q == TIMEOUT_CNT) begin
      // Line stalled mid-frame: drop the partial byte
      err_d   = 1'b1;
      state_d = IDLE;
    end else begin
      tmo_d = tmo_q + 16'd1;
    end
    busy_d = (state_d != IDLE);
  end

  // State registers; synchroniser resets high so releasing reset on idle lines gives no edge
  always_ff @(posedge clk) begin
    if (!clrn) begin
      clk_sync_q <= 3'b111;
      dat_sync_q <= 2'b11;
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      tmo_q      <= 16'd0;
      sr_q       <= 8'h00;
      data_q     <= 8'h00;
      write_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= 1'b0;
`endif
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      sr_q       <= sr_d;
      data_q     <= data_d;
      write_q    <= write_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
`ifdef PS2_PARITY_CHECK_EN
      par_q      <= par_d;
`endif
    end
  end

  assign bus.data  = data_q;
  assign bus.write = write_q;
  assign bus.err   = err_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_ps2_rx.sv
// tb_ps2_rx: directed bench for ps2_rx (TIMEOUT = 100).
// Drives PS/2 frames bit by bit; a negedge monitor records strobes, their
// cycle stamps and the written bytes (the FIFO model queue).
module tb_ps2_rx;

  logic clk = 1'b0;
  logic clrn;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ps2_rx_if bus ();

  ps2_rx #(.TIMEOUT(100)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // monitor state
  int         wr_cnt = 0;
  int         err_cnt = 0;
  int         wr_cyc = 0;
  int         err_cyc = 0;
  int         busy_cnt = 0;
  int         viol = 0;
  logic       busy_at_wr = 1'b0;
  logic       prev_wr = 1'b0;
  logic       prev_err = 1'b0;
  logic [7:0] wq[$];

  always @(negedge clk) begin
    if (bus.write === 1'b1) begin
      wr_cnt++;
      wr_cyc = cyc;
      busy_at_wr = bus.busy;
      wq.push_back(bus.data);
    end
    if (bus.err === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (bus.busy === 1'b1) busy_cnt++;
    if ((bus.write === 1'b1 && bus.err === 1'b1) ||
        (bus.write === 1'b1 && prev_wr) || (bus.err === 1'b1 && prev_err))
      viol++;
    prev_wr  = (bus.write === 1'b1);
    prev_err = (bus.err === 1'b1);
  end

  int low_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // one PS/2 bit: data set up, clock low 4 cycles, high 3+ cycles
  task automatic ps2_bit(input logic b);
    @(negedge clk) bus.ps2_data = b;
    repeat (2) @(negedge clk);
    bus.ps2_clk = 1'b0;
    low_cyc = cyc;
    repeat (4) @(negedge clk);
    bus.ps2_clk = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(stop);
  endtask

  task automatic line_idle();
    @(negedge clk) bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  int w0, e0, b0, q0, stop_low;

  initial begin
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(bus.data), 32'h00);
    check("rst_write", 32'(bus.write), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    clrn = 1'b1;
    repeat (5) @(negedge clk);

    // single frame 0x1C, parity 0
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b0, 1'b1);
    stop_low = low_cyc;
    check("single_wr", 32'(wr_cnt - w0), 32'd1);
    check("single_data", 32'(bus.data), 32'h1C);
    check("single_err", 32'(err_cnt - e0), 32'd0);
    check("single_lat", 32'(wr_cyc - stop_low), 32'd3);
    check("single_busy_wr", 32'(busy_at_wr), 32'd0);
    check("single_busy", 32'(bus.busy), 32'd0);

    // back-to-back 0xF0 (parity 1) then 0x1C (parity 0) into the FIFO model
    w0 = wr_cnt; e0 = err_cnt; q0 = wq.size();
    send_frame(8'hF0, 1'b1, 1'b1);
    send_frame(8'h1C, 1'b0, 1'b1);
    check("b2b_wr", 32'(wr_cnt - w0), 32'd2);
    check("b2b_err", 32'(err_cnt - e0), 32'd0);
    check("b2b_qsize", 32'(wq.size() - q0), 32'd2);
    if (wq.size() >= q0 + 2) begin
      check("b2b_fifo0", 32'(wq[q0]), 32'hF0);
      check("b2b_fifo1", 32'(wq[q0 + 1]), 32'h1C);
    end

    // bad stop bit on 0x5A (parity 1)
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(8'h5A, 1'b1, 1'b0);
    stop_low = low_cyc;
    line_idle();
    check("badstop_err", 32'(err_cnt - e0), 32'd1);
    check("badstop_wr", 32'(wr_cnt - w0), 32'd0);
    check("badstop_data", 32'(bus.data), 32'h1C);
    check("badstop_lat", 32'(err_cyc - stop_low), 32'd3);
    w0 = wr_cnt;
    send_frame(8'h5A, 1'b1, 1'b1);
    check("goodstop_wr", 32'(wr_cnt - w0), 32'd1);
    check("goodstop_data", 32'(bus.data), 32'h5A);

    // bad parity on 0x1C (parity bit 1)
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b1);
`ifdef PS2_PARITY_CHECK_EN
    check("badpar_err", 32'(err_cnt - e0), 32'd1);
    check("badpar_wr", 32'(wr_cnt - w0), 32'd0);
    check("badpar_data", 32'(bus.data), 32'h5A);
`else
    check("badpar_err", 32'(err_cnt - e0), 32'd0);
    check("badpar_wr", 32'(wr_cnt - w0), 32'd1);
    check("badpar_data", 32'(bus.data), 32'h1C);
`endif

    // timeout: start + 4 data bits, then ps2_clk stays high
    w0 = wr_cnt; e0 = err_cnt;
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    stop_low = low_cyc;
    check("tmo_busy_mid", 32'(bus.busy), 32'd1);
    repeat (120) @(negedge clk);
    check("tmo_err", 32'(err_cnt - e0), 32'd1);
    check("tmo_lat", 32'(err_cyc - stop_low), 32'd104);
    check("tmo_busy", 32'(bus.busy), 32'd0);
    check("tmo_wr", 32'(wr_cnt - w0), 32'd0);
    line_idle();
    w0 = wr_cnt; e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b1);
    check("after_tmo_wr", 32'(wr_cnt - w0), 32'd1);
    check("after_tmo_data", 32'(bus.data), 32'h29);
    check("after_tmo_err", 32'(err_cnt - e0), 32'd0);

    // reset mid-frame of 0xFF; the remaining bits are all 1 and must be ignored
    w0 = wr_cnt; e0 = err_cnt;
    ps2_bit(1'b0);
    for (int i = 0; i < 3; i++) ps2_bit(1'b1);
    check("mid_busy_pre", 32'(bus.busy), 32'd1);
    @(negedge clk) clrn = 1'b0;
    @(negedge clk) clrn = 1'b1;
    check("mid_rst_data", 32'(bus.data), 32'h00);
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_write", 32'(bus.write), 32'd0);
    check("mid_rst_err", 32'(bus.err), 32'd0);
    b0 = busy_cnt;
    for (int i = 0; i < 7; i++) ps2_bit(1'b1);
    repeat (5) @(negedge clk);
    check("mid_rest_wr", 32'(wr_cnt - w0), 32'd0);
    check("mid_rest_err", 32'(err_cnt - e0), 32'd0);
    check("mid_rest_busy", 32'(busy_cnt - b0), 32'd0);
    check("mid_rest_data", 32'(bus.data), 32'h00);

    // glitch: ps2_clk pulse with data high in IDLE
    e0 = err_cnt; b0 = busy_cnt;
    ps2_bit(1'b1);
    repeat (5) @(negedge clk);
    check("glitch_busy", 32'(busy_cnt - b0), 32'd0);
    check("glitch_err", 32'(err_cnt - e0), 32'd0);

    check("strobe_rules", 32'(viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
